// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell plus a carry flop, iterated over WIDTH cycles.
// Optional SERIAL_ADDER_OVERFLOW_EN adds a registered two's-complement overflow flag (ovf).
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned AW = WIDTH - 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] a_sr, a_sr_nxt;
  logic [WIDTH-1:0] b_sr, b_sr_nxt;
  logic             carry, carry_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [AW-1:0]    acc, acc_nxt;
  logic             busy_nxt, done_nxt;
  logic [WIDTH-1:0] sum_nxt;
  logic             cout_nxt;
  logic             s_bit, maj;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             ovf_nxt;
`endif

  // Next-state, datapath and output decode
  always_comb begin
    state_nxt = state;
    a_sr_nxt  = a_sr;
    b_sr_nxt  = b_sr;
    carry_nxt = carry;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    sum_nxt   = sum;
    cout_nxt  = cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ovf_nxt   = ovf;
`endif
    s_bit = a_sr[0] ^ b_sr[0] ^ carry;
    maj   = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

    case (state)
      S_IDLE: begin
        if (start) begin
          a_sr_nxt  = a;
          b_sr_nxt  = b;
          carry_nxt = cin;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        carry_nxt = maj;
        acc_nxt   = AW'({s_bit, acc} >> 1);
        a_sr_nxt  = a_sr >> 1;
        b_sr_nxt  = b_sr >> 1;
        cnt_nxt   = cnt + CW'(1);
        // The last bit lands directly in sum; acc only ever holds the lower WIDTH-1 bits
        if (cnt == CW'(WIDTH - 1)) begin
          sum_nxt   = {s_bit, acc};
          cout_nxt  = maj;
`ifdef SERIAL_ADDER_OVERFLOW_EN
          ovf_nxt   = carry ^ maj;
`endif
          done_nxt  = 1'b1;
          state_nxt = S_DONE;
        end else begin
          busy_nxt  = 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      a_sr  <= a_sr_nxt;
      b_sr  <= b_sr_nxt;
      carry <= carry_nxt;
      cnt   <= cnt_nxt;
      acc   <= acc_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      sum   <= sum_nxt;
      cout  <= cout_nxt;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf   <= ovf_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed and random 8-bit adds, plus an exhaustive 4-bit sweep.
`timescale 1ns/1ps
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic       ovf8, ovf4;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] prev_sum;
  logic       prev_cout;
  logic       prev_ovf;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    , .ovf(ovf4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One 8-bit addition with timing checks; optionally pokes start on a busy cycle and/or in the done cycle
  task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                      input int inj_busy, input bit inj_done);
    logic [8:0] full;
    logic       e_ovf;
    full  = {1'b0, ia} + {1'b0, ib} + {8'd0, icin};
    e_ovf = (ia[7] == ib[7]) && (full[7] != ia[7]);
    @(negedge clk);
    a8 = ia; b8 = ib; cin8 = icin; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~ia; b8 = ~ib; cin8 = ~icin;
    for (int i = 1; i <= 8; i++) begin
      chk("busy_hi", busy8, 1);
      chk("done_lo_busy", done8, 0);
      chk("sum_hold", sum8, prev_sum);
      chk("cout_hold", cout8, prev_cout);
      if (i == inj_busy) begin
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
    end
    chk("done_hi", done8, 1);
    chk("busy_lo_done", busy8, 0);
    chk("sum", sum8, full[7:0]);
    chk("cout", cout8, full[8]);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    chk("ovf", ovf8, e_ovf);
`endif
    if (inj_done) begin
      start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
    end
    @(negedge clk);
    start8 = 1'b0;
    chk("done_pulse_end", done8, 0);
    chk("idle_busy_lo", busy8, 0);
    @(negedge clk);
    chk("no_restart_busy", busy8, 0);
    chk("no_second_done", done8, 0);
    chk("sum_after", sum8, full[7:0]);
    prev_sum  = full[7:0];
    prev_cout = full[8];
    prev_ovf  = e_ovf;
  endtask

  initial begin
    int cycles;
    logic [4:0] full4;
    logic [8:0] vec;

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_sum", sum8, 0);
    chk("rst_cout", cout8, 0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    chk("rst_ovf", ovf8, 0);
`endif

    // Directed cases
    run8(8'h3C, 8'h45, 1'b0, -1, 1'b0);
    chk("tp_3c45", sum8, 8'h81);
    run8(8'hFF, 8'h01, 1'b0, -1, 1'b0);
    run8(8'hFF, 8'hFF, 1'b1, -1, 1'b0);
    run8(8'h7F, 8'h01, 1'b0, -1, 1'b0);
    run8(8'h80, 8'h80, 1'b0, -1, 1'b0);
    run8(8'h10, 8'h20, 1'b0, 3, 1'b1);
    chk("tp_ignored_start", sum8, 8'h30);

    // Reset aborts an operation in flight
    run8(8'h3C, 8'h45, 1'b0, -1, 1'b0);
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy8, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_sum", sum8, 0);
    chk("abort_cout", cout8, 0);
    prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("abort_no_done", done8, 0);
      @(negedge clk);
    end
    run8(8'h02, 8'h03, 1'b0, -1, 1'b0);

    // Reset wins over a simultaneous start
    rst = 1'b1; start8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
    @(negedge clk);
    rst = 1'b0; start8 = 1'b0;
    chk("rst_start_busy", busy8, 0);
    chk("rst_start_sum", sum8, 0);
    @(negedge clk);
    chk("rst_start_busy2", busy8, 0);
    prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;

    // Random 8-bit operations
    repeat (20) begin
      vec = 9'($urandom);
      run8(8'($urandom), vec[7:0], vec[8], -1, 1'b0);
    end

    // Exhaustive 4-bit sweep with start held high; done spacing must be 6 cycles
    @(negedge clk);
    start4 = 1'b1;
    for (int k = 0; k < 512; k++) begin
      a4 = 4'(k >> 5); b4 = 4'(k >> 1); cin4 = k[0];
      full4 = {1'b0, a4} + {1'b0, b4} + {4'd0, cin4};
      cycles = 0;
      do begin
        @(negedge clk);
        cycles++;
      end while (done4 !== 1'b1 && cycles < 20);
      chk("sweep_spacing", cycles, (k == 0) ? 5 : 6);
      chk("sweep_sum", sum4, full4[3:0]);
      chk("sweep_cout", cout4, full4[4]);
`ifdef SERIAL_ADDER_OVERFLOW_EN
      chk("sweep_ovf", ovf4, (a4[3] == b4[3]) && (full4[3] != a4[3]));
`endif
    end
    start4 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
